music_key_tone_generator: RTL and testbench
===========================================

Name: music_key_tone_generator

Overview:
- Converts the 6-bit held-key vector from the music-keys controller into a signed PCM audio sample stream.
- Runs one square-wave voice per key, with fixed pitches C4, D4, E4, F4, G4 and A4.
- Mixes the active voices and emits one sample per sample-rate strobe.
- Sits directly downstream of the music-keys controller and upstream of the audio output / recording path.

Parameters:
- SAMPLE_DIV, 1134, clocks per output sample (50 MHz / 1134 ≈ 44.09 kHz).
- AMPLITUDE, 4000, per-voice magnitude in LSBs; 6*AMPLITUDE must be ≤ 32767.
- HALF_PERIOD_0..5, 95556 / 85131 / 75843 / 71586 / 63776 / 56818, half-period in clocks for keys 0..5 (C4, D4, E4, F4, G4, A4).

Ports:
- clock_50Mhz  input  1  system clock, 50 MHz.
- reset  input  1  synchronous reset, active-high.
- input_KeyPressed  input  6  held-key vector, bit i = key i active, already debounced and state-gated.
- output_Sample  output  16  signed two's-complement mixed sample.
- output_SampleValid  output  1  one-cycle strobe; output_Sample is valid and stable on this cycle.
- output_ActiveVoices  output  3  count of voices currently sounding, 0..6.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - output_Sample = 0, output_SampleValid = 0, output_ActiveVoices = 0.
  - All voice counters = 0, all voice polarities = 0.
  - Sample divider = 0.
- Reset mid-operation: all state clears on the next edge. The first strobe after reset release comes SAMPLE_DIV clocks after the first non-reset edge.
- Key capture: input_KeyPressed is registered once to form voice_en[5:0]. Voice latency from key change to voice start/stop is 1 clock.
- Voice i, voice_en[i] = 0:
  - counter_i and polarity_i forced to 0 (phase restarts on every press).
- Voice i, voice_en[i] = 1:
  - counter_i increments each clock.
  - When counter_i = HALF_PERIOD_i - 1: counter_i ← 0 and polarity_i toggles.
  - Counters are 17 bits unsigned.
- Voice contribution:
  - Disabled voice contributes 0.
  - Enabled voice with polarity 1 contributes +AMPLITUDE.
  - Enabled voice with polarity 0 contributes -AMPLITUDE.
- Mix:
  - Signed sum of the 6 contributions, computed in 16 bits.
  - Range is bounded to ±24000 by the parameter rule, so no overflow or saturation logic is required.
  - Width check: implementation asserts 6*AMPLITUDE ≤ 32767 at elaboration.
- Sample divider:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - On the edge where the divider is at SAMPLE_DIV-1, the block registers:
    - output_Sample ← mix of voice_en and polarities as they stood before that edge;
    - output_ActiveVoices ← popcount(voice_en);
    - output_SampleValid ← 1 for exactly that following cycle.
  - At all other times output_SampleValid = 0, and output_Sample / output_ActiveVoices hold their values.
- Strobe spacing: exactly SAMPLE_DIV clocks, independent of key activity.
- Silence: no keys held gives output_Sample = 0 at every strobe, and output_ActiveVoices = 0.
- Simultaneous events:
  - A key press on the same edge as a strobe is not reflected until the next strobe, because the mix uses pre-edge voice_en.
  - A key release on the same edge as a polarity toggle: release wins, so polarity → 0 and counter → 0.
- All 6 keys held: sum in {-24000, -16000, …, +24000}, always an even multiple of AMPLITUDE offset from ±24000.

Test Plan:
- Reset held 5 clocks with keys = 6'b111111 → all outputs 0 throughout. After release, first output_SampleValid occurs exactly 1134 clocks later.
- Keys = 0 for 10 strobes → every strobe has output_Sample = 0, output_ActiveVoices = 0, and strobe spacing is exactly 1134 clocks.
- Key 5 (A4) held from reset release:
  - First strobe output_Sample = -4000.
  - Polarity toggles every 56818 clocks; measured full period is 113636 clocks ±0.
  - output_ActiveVoices = 1.
- Keys 0 and 5 pressed on the same edge → first strobe gives -8000 and output_ActiveVoices = 2. After 56818 clocks key 5 is +, giving 0. After 95556 clocks both are +, giving +8000.
- All 6 keys held → output_ActiveVoices = 6, first sample -24000, no value ever outside ±24000. Releasing key 2 mid-cycle gives output_ActiveVoices = 5 at the next strobe, with the mix excluding voice 2.
- Key 3 released on the exact edge where its counter = 71585 → polarity_3 = 0 and counter_3 = 0. Re-press restarts the phase: first toggle occurs 71586 clocks after voice_en rises.

Source files
------------

// File: rtl/music_key_tone_generator.sv
// Six-voice square-wave tone generator: one fixed-pitch voice per held key,
// mixed into a signed 16-bit PCM sample emitted once per sample-rate strobe.
module music_key_tone_generator #(
  parameter int unsigned SAMPLE_DIV    = 1134,
  parameter int unsigned AMPLITUDE     = 4000,
  parameter int unsigned HALF_PERIOD_0 = 95556,
  parameter int unsigned HALF_PERIOD_1 = 85131,
  parameter int unsigned HALF_PERIOD_2 = 75843,
  parameter int unsigned HALF_PERIOD_3 = 71586,
  parameter int unsigned HALF_PERIOD_4 = 63776,
  parameter int unsigned HALF_PERIOD_5 = 56818
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic [5:0]  input_KeyPressed,
  output logic [15:0] output_Sample,
  output logic        output_SampleValid,
  output logic [2:0]  output_ActiveVoices
);

  localparam int unsigned NUM_VOICES = 6;
  localparam int unsigned CNT_W      = 17;
  localparam int unsigned SMP_W      = 16;
  localparam int unsigned ACT_W      = 3;
  localparam int unsigned DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST [NUM_VOICES] = '{
    CNT_W'(HALF_PERIOD_0 - 1), CNT_W'(HALF_PERIOD_1 - 1), CNT_W'(HALF_PERIOD_2 - 1),
    CNT_W'(HALF_PERIOD_3 - 1), CNT_W'(HALF_PERIOD_4 - 1), CNT_W'(HALF_PERIOD_5 - 1)
  };
  localparam logic signed [SMP_W-1:0] AMP_P = SMP_W'(AMPLITUDE);
  localparam logic signed [SMP_W-1:0] AMP_N = -AMP_P;
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  // The six-voice mix must fit a signed 16-bit sample without saturation.
  if (6 * AMPLITUDE > 32767) begin : g_amp_too_large
    $error("AMPLITUDE too large for a 6-voice 16-bit mix");
  end

  logic [NUM_VOICES-1:0]   voice_en_q, voice_en_d;
  logic [CNT_W-1:0]        cnt_q [NUM_VOICES];
  logic [CNT_W-1:0]        cnt_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   pol_q, pol_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [SMP_W-1:0]        sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic [ACT_W-1:0]        active_q, active_d;

  logic signed [SMP_W-1:0] mix_c;
  logic [ACT_W-1:0]        active_c;
  logic                    div_last_c;

  // Voice counters run only while the key stays held across the edge, so a
  // release coinciding with a toggle leaves the voice cleared.
  always_comb begin
    voice_en_d = input_KeyPressed;
    pol_d      = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      cnt_d[i] = '0;
      if (voice_en_q[i] && voice_en_d[i]) begin
        if (cnt_q[i] == HALF_LAST[i]) begin
          pol_d[i] = ~pol_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          pol_d[i] = pol_q[i];
        end
      end
    end
  end

  // Mix and voice count from the pre-edge voice state.
  always_comb begin
    mix_c    = '0;
    active_c = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_en_q[i]) begin
        mix_c    = mix_c + (pol_q[i] ? AMP_P : AMP_N);
        active_c = active_c + ACT_W'(1);
      end
    end
  end

  always_comb begin
    div_last_c = (div_q == DIV_LAST);
    div_d      = div_last_c ? '0 : div_q + DIV_W'(1);
    valid_d    = div_last_c;
    sample_d   = div_last_c ? SMP_W'(mix_c) : sample_q;
    active_d   = div_last_c ? active_c : active_q;
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      voice_en_q <= '0;
      pol_q      <= '0;
      div_q      <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      active_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) cnt_q[i] <= '0;
    end else begin
      voice_en_q <= voice_en_d;
      pol_q      <= pol_d;
      div_q      <= div_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      for (int i = 0; i < NUM_VOICES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign output_Sample       = sample_q;
  assign output_SampleValid  = valid_q;
  assign output_ActiveVoices = active_q;

endmodule

// File: tb/tb_music_key_tone_generator.sv
// Self-checking bench for music_key_tone_generator using shortened periods and
// a time-based reference model (phase derived from press time, not counters).
module tb_music_key_tone_generator;

  localparam int SD  = 40;
  localparam int AMP = 4000;
  localparam int HP0 = 97, HP1 = 83, HP2 = 71, HP3 = 67, HP4 = 59, HP5 = 47;

  logic        clk;
  logic        reset;
  logic [5:0]  keys;
  logic [15:0] sample;
  logic        valid;
  logic [2:0]  active;

  music_key_tone_generator #(
    .SAMPLE_DIV(SD), .AMPLITUDE(AMP),
    .HALF_PERIOD_0(HP0), .HALF_PERIOD_1(HP1), .HALF_PERIOD_2(HP2),
    .HALF_PERIOD_3(HP3), .HALF_PERIOD_4(HP4), .HALF_PERIOD_5(HP5)
  ) dut (
    .clock_50Mhz(clk),
    .reset(reset),
    .input_KeyPressed(keys),
    .output_Sample(sample),
    .output_SampleValid(valid),
    .output_ActiveVoices(active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int hp [6] = '{HP0, HP1, HP2, HP3, HP4, HP5};
  int t;
  bit en [6];
  int since [6];
  int exp_sample, exp_active, exp_valid;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at t=%0d", tag, obs, expv, t);
    end
  endtask

  function automatic int model_pol(input int i);
    if (!en[i]) return 0;
    return ((t - since[i]) / hp[i]) % 2;
  endfunction

  function automatic int model_mix();
    int s = 0;
    for (int i = 0; i < 6; i++)
      if (en[i]) s += (model_pol(i) != 0) ? AMP : -AMP;
    return s;
  endfunction

  function automatic int model_active();
    int n = 0;
    for (int i = 0; i < 6; i++) n += int'(en[i]);
    return n;
  endfunction

  // One clock: advance the model across the edge, then compare after it.
  task automatic tick();
    int pre_mix, pre_act, pol_vec;
    pre_mix = model_mix();
    pre_act = model_active();
    @(posedge clk);
    if (reset) begin
      t = 0;
      for (int i = 0; i < 6; i++) en[i] = 0;
      exp_sample = 0; exp_active = 0; exp_valid = 0;
    end else begin
      t++;
      for (int i = 0; i < 6; i++) begin
        if (keys[i] && !en[i]) since[i] = t;
        en[i] = keys[i];
      end
      if (t % SD == 0) begin
        exp_valid = 1; exp_sample = pre_mix; exp_active = pre_act;
      end else begin
        exp_valid = 0;
      end
    end
    #1;
    pol_vec = 0;
    for (int i = 0; i < 6; i++) pol_vec |= model_pol(i) << i;
    check("valid",  int'(valid), exp_valid);
    check("sample", int'($signed(sample)), exp_sample);
    check("active", int'(active), exp_active);
    check("polarity", int'(dut.pol_q), pol_vec);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    clk = 0; reset = 1; keys = 6'b111111;
    t = 0; exp_sample = 0; exp_active = 0; exp_valid = 0;
    for (int i = 0; i < 6; i++) begin en[i] = 0; since[i] = 0; end

    // Reset with all keys held, then silence for 10 strobes.
    run(5);
    reset = 0; keys = 6'b000000;
    run(10 * SD);

    // Key 5 alone through several periods.
    reset = 1; run(2); reset = 0; keys = 6'b100000;
    run(4 * HP5 + SD + 3);

    // Keys 0 and 5 pressed on the same edge.
    keys = 6'b000000; run(3);
    keys = 6'b100001; run(2 * HP0 + 2 * SD);

    // All keys, then release key 2 mid-cycle.
    keys = 6'b000000; run(2);
    keys = 6'b111111; run(3 * SD + 7);
    keys = 6'b111011; run(2 * SD);

    // Key 3 released exactly on its toggle edge, then re-pressed.
    keys = 6'b001000; run(2);
    while (((t - since[3]) % HP3) != HP3 - 1) tick();
    keys = 6'b000000; tick();
    check("cnt3_after_release", int'(dut.cnt_q[3]), 0);
    check("pol3_after_release", int'(dut.pol_q[3]), 0);
    run(3);
    keys = 6'b001000; run(2 * HP3 + 3);

    // Mid-operation reset.
    keys = 6'b010110; run(SD / 2);
    reset = 1; run(1); reset = 0; run(2 * SD + 1);

    // Randomized key sequences.
    for (int seg = 0; seg < 50; seg++) begin
      keys = 6'($urandom_range(0, 63));
      run(int'($urandom_range(1, 150)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
